// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point definitions for the CNN datapath: default widths,
// output saturation limits, burst state encoding and the rounding shift.
package cnn_fixed_pkg;

  localparam int CNN_DW   = 8;
  localparam int CNN_FRAC = 8;
  localparam int CNN_OW   = 15;

  localparam logic signed [CNN_OW-1:0] SAT_MAX = {1'b0, {(CNN_OW-1){1'b1}}};
  localparam logic signed [CNN_OW-1:0] SAT_MIN = {1'b1, {(CNN_OW-1){1'b0}}};

  typedef enum logic {
    BURST_IDLE  = 1'b0,
    BURST_ACCUM = 1'b1
  } burst_state_e;

  // Round half up then arithmetic shift right; 64-bit so callers never overflow on the +half.
  function automatic logic signed [63:0] round_half_up_shr(input logic signed [63:0] v,
                                                          input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (v + half) >>> frac;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational accumulator-to-output conversion: round half up, drop FRAC
// fractional bits, saturate to OW signed bits and flag any clipping.
module fixed_round_sat
  import cnn_fixed_pkg::*;
#(
  parameter int ACCW = 24,
  parameter int FRAC = CNN_FRAC,
  parameter int OW   = CNN_OW
) (
  input  logic signed [ACCW-1:0] acc_i,
  output logic signed [OW-1:0]   res_o,
  output logic                   clip_o
);

  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (OW - 1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (OW - 1));

  function automatic logic signed [OW-1:0] sat_ow(input logic signed [63:0] v,
                                                 output logic clip);
    clip = 1'b1;
    if (v > OUT_MAX) return OUT_MAX[OW-1:0];
    if (v < OUT_MIN) return OUT_MIN[OW-1:0];
    clip = 1'b0;
    return v[OW-1:0];
  endfunction

  logic signed [63:0] shifted;

  // Round/shift the widened accumulator, then clip into the output range.
  always_comb begin
    shifted = round_half_up_shr(64'(acc_i), FRAC);
    res_o   = sat_ow(shifted, clip_o);
  end

endmodule

// File: rtl/fixed_mac_pipe.sv
// Pipelined signed fixed-point MAC: LANES products per beat, summed and
// accumulated over a first..last burst, emitted rounded and saturated.
// A single global stall (output held, not taken) freezes every stage.
module fixed_mac_pipe
  import cnn_fixed_pkg::*;
#(
  parameter int DW    = CNN_DW,
  parameter int LANES = 4,
  parameter int FRAC  = CNN_FRAC,
  parameter int ACCW  = 24,
  parameter int OW    = CNN_OW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [LANES*DW-1:0]    in_a,
  input  logic [LANES*DW-1:0]    in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OW-1:0]   out_data,
  output logic                   out_sat,
  output logic                   busy
);

  localparam int PW     = 2 * DW;
  localparam int LEVELS = $clog2(LANES);
  localparam int NODES  = 2 * LANES - 1;

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  // Two's-complement add that clamps to the accumulator range instead of wrapping.
  function automatic logic signed [ACCW-1:0] acc_sat_add(input logic signed [ACCW-1:0] a,
                                                        input logic signed [ACCW-1:0] b,
                                                        output logic ovf);
    logic signed [ACCW:0] wide;
    wide = {a[ACCW-1], a} + {b[ACCW-1], b};
    ovf  = wide[ACCW] ^ wide[ACCW-1];
    if (!ovf) return wide[ACCW-1:0];
    return wide[ACCW] ? ACC_MIN : ACC_MAX;
  endfunction

  logic stall, adv, accept;

  logic                 vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
  logic signed [PW-1:0] prod_p1_q [LANES];
  logic signed [PW-1:0] prod_p1_d [LANES];

  logic                   vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
  logic signed [ACCW-1:0] sum_p2_q, sum_p2_d;

  logic signed [ACCW-1:0] acc_q, acc_d, acc_base, acc_sum;
  logic                   ovf_q, ovf_d, ovf_base, add_ovf;
  logic                   vld_p3_q, vld_p3_d, ovf_p3_q, ovf_p3_d;
  logic signed [ACCW-1:0] res_p3_q, res_p3_d;

  logic                 out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic signed [OW-1:0] out_data_q, out_data_d, rs_data;
  logic                 rs_clip;

  burst_state_e state_q, state_d;

  logic signed [ACCW-1:0] tree [NODES];

  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = reset & adv;
  assign accept   = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = vld_p1_q | vld_p2_q | vld_p3_q | out_valid_q | (state_q == BURST_ACCUM);

  // Adder tree: leaves are sign-extended products, each level halves the node count.
  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign tree[i] = ACCW'(prod_p1_q[i]);
  end
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SRC = 2 * LANES - 2 * (LANES >> l);
    localparam int DST = 2 * LANES - 2 * (LANES >> (l + 1));
    for (genvar j = 0; j < (LANES >> (l + 1)); j++) begin : g_node
      assign tree[DST + j] = tree[SRC + 2*j] + tree[SRC + 2*j + 1];
    end
  end

  // S1: capture the accepted beat as LANES full-width products.
  always_comb begin
    vld_p1_d   = vld_p1_q;
    first_p1_d = first_p1_q;
    last_p1_d  = last_p1_q;
    prod_p1_d  = prod_p1_q;
    if (adv) begin
      vld_p1_d   = accept;
      first_p1_d = in_first;
      last_p1_d  = in_last;
      for (int i = 0; i < LANES; i++) begin
        prod_p1_d[i] = PW'($signed(in_a[i*DW +: DW])) * PW'($signed(in_b[i*DW +: DW]));
      end
    end
  end

  // S2: register the adder-tree root.
  always_comb begin
    vld_p2_d   = vld_p2_q;
    first_p2_d = first_p2_q;
    last_p2_d  = last_p2_q;
    sum_p2_d   = sum_p2_q;
    if (adv) begin
      vld_p2_d   = vld_p1_q;
      first_p2_d = first_p1_q;
      last_p2_d  = last_p1_q;
      sum_p2_d   = tree[NODES-1];
    end
  end

  // S3: saturating accumulate; a last beat hands the total to S4 and clears acc/ovf.
  always_comb begin
    acc_base = first_p2_q ? '0 : acc_q;
    ovf_base = first_p2_q ? 1'b0 : ovf_q;
    acc_sum  = acc_sat_add(acc_base, sum_p2_q, add_ovf);
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    vld_p3_d = vld_p3_q;
    res_p3_d = res_p3_q;
    ovf_p3_d = ovf_p3_q;
    if (adv) begin
      vld_p3_d = vld_p2_q & last_p2_q;
      res_p3_d = acc_sum;
      ovf_p3_d = ovf_base | add_ovf;
      if (vld_p2_q) begin
        acc_d = last_p2_q ? '0 : acc_sum;
        ovf_d = last_p2_q ? 1'b0 : (ovf_base | add_ovf);
      end
    end
  end

  fixed_round_sat #(
    .ACCW (ACCW),
    .FRAC (FRAC),
    .OW   (OW)
  ) u_round_sat (
    .acc_i  (res_p3_q),
    .res_o  (rs_data),
    .clip_o (rs_clip)
  );

  // S4: output register, held while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (adv) begin
      out_valid_d = vld_p3_q;
      if (vld_p3_q) begin
        out_data_d = rs_data;
        out_sat_d  = rs_clip | ovf_p3_q;
      end
    end
  end

  // Burst tracking on accepted beats; first&last stays IDLE.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_last)       state_d = BURST_IDLE;
      else if (in_first) state_d = BURST_ACCUM;
    end
  end

  // Control and architecturally visible state, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      last_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      first_p2_q  <= 1'b0;
      last_p2_q   <= 1'b0;
      vld_p3_q    <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      state_q     <= BURST_IDLE;
    end else begin
      vld_p1_q    <= vld_p1_d;
      first_p1_q  <= first_p1_d;
      last_p1_q   <= last_p1_d;
      vld_p2_q    <= vld_p2_d;
      first_p2_q  <= first_p2_d;
      last_p2_q   <= last_p2_d;
      vld_p3_q    <= vld_p3_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      state_q     <= state_d;
    end
  end

  // Pipeline data registers; only meaningful alongside their valid bits.
  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    sum_p2_q  <= sum_p2_d;
    res_p3_q  <= res_p3_d;
    ovf_p3_q  <= ovf_p3_d;
  end

endmodule
